// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: RISC-V load/store funct3 encodings,
// the bus-access FSM state type and the access-size helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Access size in bytes from funct3; callers clamp to the datapath width.
  function automatic logic [3:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 4'd1;
      2'b01:   size_of = 4'd2;
      2'b10:   size_of = 4'd4;
      default: size_of = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/response bus. The LSU is the master; the
// memory (or a testbench model) is the slave.
interface mem_stage_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  localparam int NBYTES = XLEN / 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [NBYTES-1:0] be;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store data replication and byte enables, and
// load extraction with sign/zero extension. Sub-size address bits are
// dropped so every access lands on a naturally aligned lane group.
module mem_lsu_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [XLEN-1:0]            st_data,
  input  logic [XLEN-1:0]            ld_raw,
  output logic [XLEN-1:0]            st_wdata,
  output logic [XLEN/8-1:0]          st_be,
  output logic [XLEN-1:0]            ld_data
);
  localparam int NBYTES = XLEN / 8;
  localparam int OFF_W  = $clog2(NBYTES);

  logic [3:0]       sz_raw;
  logic [3:0]       sz;
  logic [OFF_W-1:0] off_al;
  logic [XLEN-1:0]  sh;
  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;
  logic signed [31:0] ld_w;

  assign sz_raw = size_of(funct3);
  assign sz     = (sz_raw > 4'(NBYTES)) ? 4'(NBYTES) : sz_raw;
  assign off_al = off & ~OFF_W'(sz - 4'd1);

  // Store path: replicate the low sz bytes across the bus and enable sz lanes at off_al.
  always_comb begin
    st_wdata = '0;
    st_be    = '0;
    for (int i = 0; i < NBYTES; i++) begin
      case (sz)
        4'd1:    st_wdata[i*8 +: 8] = st_data[7:0];
        4'd2:    st_wdata[i*8 +: 8] = st_data[(i % 2)*8 +: 8];
        4'd4:    st_wdata[i*8 +: 8] = st_data[(i % 4)*8 +: 8];
        default: st_wdata[i*8 +: 8] = st_data[i*8 +: 8];
      endcase
      st_be[i] = (i >= int'(off_al)) && (i < int'(off_al) + int'(sz));
    end
  end

  assign sh   = ld_raw >> (int'(off_al) * 8);
  assign ld_b = sh[7:0];
  assign ld_h = sh[15:0];
  assign ld_w = sh[31:0];

  // Load path: extend the addressed field according to funct3.
  always_comb begin
    ld_data = sh;
    case (funct3)
      F3_B:    ld_data = XLEN'(ld_b);
      F3_H:    ld_data = XLEN'(ld_h);
      F3_W:    ld_data = XLEN'(ld_w);
      F3_D:    ld_data = sh;
      F3_BU:   ld_data = XLEN'(sh[7:0]);
      F3_HU:   ld_data = XLEN'(sh[15:0]);
      F3_WU:   ld_data = XLEN'(sh[31:0]);
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with sized loads/stores over a variable-latency
// request/grant/response bus. Owns the MEM/WB register and the branch
// decision. Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses are
// not issued and are flagged on wb_misalign instead of being force-aligned.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [XLEN-1:0]      ex_alu_res,
  input  logic [XLEN-1:0]      ex_wdata,
  input  logic [4:0]           ex_rd,
  input  logic [2:0]           ex_funct3,
  input  logic                 ex_branch,
  input  logic                 ex_zero,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic                 ex_mem2reg,
  input  logic                 ex_reg_write,
  input  logic                 flush,
  mem_stage_lsu_if.master      dmem,
  output logic                 mem_stall,
  output logic                 pc_src,
  output logic                 wb_valid,
  output logic                 wb_mem2reg,
  output logic                 wb_reg_write,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_mem_data,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                 wb_misalign,
`endif
  output logic [XLEN-1:0]      wb_alu_res
);
  localparam int NBYTES = XLEN / 8;
  localparam int OFF_W  = $clog2(NBYTES);

  state_t          state;
  logic            acc;
  logic            acc_bus;
  logic            misal;
  logic            done;
  logic [XLEN-1:0] ld_data;

  assign acc = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  logic [3:0] sz_raw;
  logic [3:0] sz;
  assign sz_raw  = size_of(ex_funct3);
  assign sz      = (sz_raw > 4'(NBYTES)) ? 4'(NBYTES) : sz_raw;
  assign misal   = acc & (|(ex_alu_res[OFF_W-1:0] & OFF_W'(sz - 4'd1)));
`else
  assign misal   = 1'b0;
`endif
  assign acc_bus = acc & ~misal;

  mem_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3   (ex_funct3),
    .off      (ex_alu_res[OFF_W-1:0]),
    .st_data  (ex_wdata),
    .ld_raw   (dmem.rdata),
    .st_wdata (dmem.wdata),
    .st_be    (dmem.be),
    .ld_data  (ld_data)
  );

  // Once raised in REQ the request stays up until granted; write wins over read.
  assign dmem.req  = (state == REQ) | ((state == IDLE) & acc_bus);
  assign dmem.we   = ex_mem_write;
  assign dmem.addr = ex_alu_res[ADDR_W-1:0] & ~ADDR_W'(NBYTES - 1);

  assign done      = (dmem.req & dmem.gnt & ex_mem_write) |
                     ((state == RESP) & dmem.rvalid);
  assign mem_stall = acc_bus & ~done;
  assign pc_src    = ex_valid & ex_branch & ex_zero;

  // Bus FSM: wait for grant, then for load data; rvalid outside RESP is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, REQ: begin
          if (dmem.req) begin
            if (dmem.gnt) state <= ex_mem_write ? IDLE : RESP;
            else          state <= REQ;
          end
        end
        RESP:    if (dmem.rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- MEM / WB boundary ----
  // Capture the instruction, or a bubble while stalled or flushed (data held).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_mem2reg   <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_mem_data  <= '0;
      wb_alu_res   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign  <= 1'b0;
`endif
    end else if (flush | mem_stall) begin
      wb_valid     <= 1'b0;
      wb_mem2reg   <= 1'b0;
      wb_reg_write <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign  <= 1'b0;
`endif
    end else begin
      wb_valid     <= ex_valid;
      wb_mem2reg   <= ex_mem2reg;
      wb_reg_write <= ex_reg_write & ex_valid & ~misal;
      wb_rd        <= ex_rd;
      wb_mem_data  <= ld_data;
      wb_alu_res   <= ex_alu_res;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign  <= misal;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=32): stores, sized loads with bus
// latency, grant back-pressure, flush, branch decision and reset recovery.
module tb_mem_stage_lsu;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_branch, ex_zero, ex_mem_read, ex_mem_write;
  logic        ex_mem2reg, ex_reg_write, flush;
  logic [31:0] ex_alu_res, ex_wdata;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        mem_stall, pc_src, wb_valid, wb_mem2reg, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_mem_data, wb_alu_res;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        wb_misalign;
`endif

  int n_checks = 0;
  int n_err    = 0;

  mem_stage_lsu_if #(.XLEN(32), .ADDR_W(32)) dmem ();

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_alu_res   (ex_alu_res),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .ex_funct3    (ex_funct3),
    .ex_branch    (ex_branch),
    .ex_zero      (ex_zero),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_mem2reg   (ex_mem2reg),
    .ex_reg_write (ex_reg_write),
    .flush        (flush),
    .dmem         (dmem),
    .mem_stall    (mem_stall),
    .pc_src       (pc_src),
    .wb_valid     (wb_valid),
    .wb_mem2reg   (wb_mem2reg),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_mem_data  (wb_mem_data),
`ifdef MEM_MISALIGN_TRAP_EN
    .wb_misalign  (wb_misalign),
`endif
    .wb_alu_res   (wb_alu_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_branch = 0; ex_zero = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_mem2reg = 0; ex_reg_write = 0; ex_alu_res = '0; ex_wdata = '0;
    ex_rd = '0; ex_funct3 = F3_W;
  endtask

  task automatic drive_ld(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
    clr_ex();
    ex_valid = 1; ex_mem_read = 1; ex_mem2reg = 1; ex_reg_write = 1;
    ex_alu_res = a; ex_funct3 = f3; ex_rd = rd;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    clr_ex();
    ex_valid = 1; ex_mem_write = 1; ex_alu_res = a; ex_funct3 = f3; ex_wdata = d;
  endtask

  initial begin
    rst = 1; flush = 0;
    clr_ex();
    dmem.gnt = 0; dmem.rvalid = 0; dmem.rdata = '0;
    tick(); tick();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_regwr", wb_reg_write, 0);
    chk("rst_wb_data", wb_mem_data, 0);
    chk("rst_req", dmem.req, 0);
    rst = 0;
    tick();

    // SW 0x100, granted at once
    drive_st(32'h100, F3_W, 32'hDEADBEEF); dmem.gnt = 1;
    #1;
    chk("sw_req", dmem.req, 1);
    chk("sw_we", dmem.we, 1);
    chk("sw_addr", dmem.addr, 32'h100);
    chk("sw_be", dmem.be, 4'hF);
    chk("sw_wdata", dmem.wdata, 32'hDEADBEEF);
    chk("sw_stall", mem_stall, 0);
    tick();
    chk("sw_wb_valid", wb_valid, 1);
    chk("sw_wb_regwr", wb_reg_write, 0);

    // SB 0x103
    drive_st(32'h103, F3_B, 32'h000000A5);
    #1;
    chk("sb_be", dmem.be, 4'h8);
    chk("sb_wdata", dmem.wdata, 32'hA5A5A5A5);
    chk("sb_addr", dmem.addr, 32'h100);
    chk("sb_stall", mem_stall, 0);
    tick();

    // LB 0x101: gnt in cycle 0, rvalid in cycle 3
    drive_ld(32'h101, F3_B, 5'd5); dmem.gnt = 1;
    #1;
    chk("lb_c0_req", dmem.req, 1);
    chk("lb_c0_we", dmem.we, 0);
    chk("lb_c0_stall", mem_stall, 1);
    tick(); dmem.gnt = 0;
    #1;
    chk("lb_c1_req", dmem.req, 0);
    chk("lb_c1_stall", mem_stall, 1);
    chk("lb_c1_bubble", wb_valid, 0);
    tick();
    #1;
    chk("lb_c2_stall", mem_stall, 1);
    tick(); dmem.rvalid = 1; dmem.rdata = 32'h00008000;
    #1;
    chk("lb_c3_stall", mem_stall, 0);
    tick(); dmem.rvalid = 0;
    chk("lb_data", wb_mem_data, 32'hFFFFFF80);
    chk("lb_valid", wb_valid, 1);
    chk("lb_regwr", wb_reg_write, 1);
    chk("lb_rd", wb_rd, 5);
    chk("lb_m2r", wb_mem2reg, 1);
    chk("lb_alu", wb_alu_res, 32'h101);

    // LBU on the same data, rvalid one cycle after gnt
    drive_ld(32'h101, F3_BU, 5'd6); dmem.gnt = 1;
    #1;
    chk("lbu_stall", mem_stall, 1);
    tick(); dmem.gnt = 0; dmem.rvalid = 1; dmem.rdata = 32'h00008000;
    #1;
    chk("lbu_done", mem_stall, 0);
    tick(); dmem.rvalid = 0;
    chk("lbu_data", wb_mem_data, 32'h00000080);

    // LH 0x102, gnt withheld 2 cycles, flush in the rvalid cycle
    drive_ld(32'h102, F3_H, 5'd7); dmem.gnt = 0;
    #1;
    chk("lh_c0_req", dmem.req, 1);
    chk("lh_c0_be", dmem.be, 4'hC);
    chk("lh_c0_stall", mem_stall, 1);
    tick();
    #1;
    chk("lh_c1_req", dmem.req, 1);
    chk("lh_c1_addr", dmem.addr, 32'h100);
    chk("lh_c1_be", dmem.be, 4'hC);
    tick(); dmem.gnt = 1;
    #1;
    chk("lh_c2_req", dmem.req, 1);
    chk("lh_c2_stall", mem_stall, 1);
    tick(); dmem.gnt = 0; dmem.rvalid = 1; dmem.rdata = 32'hBEEF0000; flush = 1;
    #1;
    chk("lh_c3_stall", mem_stall, 0);
    tick(); dmem.rvalid = 0; flush = 0;
    chk("lh_flush_valid", wb_valid, 0);
    chk("lh_flush_regwr", wb_reg_write, 0);

    // LHU 0x102, gnt withheld 1 cycle, no flush: data must arrive
    drive_ld(32'h102, F3_HU, 5'd8);
    #1;
    chk("lhu_c0_stall", mem_stall, 1);
    tick(); dmem.gnt = 1;
    tick(); dmem.gnt = 0; dmem.rvalid = 1; dmem.rdata = 32'hBEEF0000;
    tick(); dmem.rvalid = 0;
    chk("lhu_data", wb_mem_data, 32'h0000BEEF);
    chk("lhu_valid", wb_valid, 1);

    // Branch decision
    clr_ex(); ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_alu_res = 32'h40;
    #1;
    chk("beq_taken", pc_src, 1);
    ex_valid = 0;
    #1;
    chk("beq_invalid", pc_src, 0);
    ex_valid = 1;
    tick();
    chk("beq_wb_alu", wb_alu_res, 32'h40);

    // Reset while in RESP, then stale rvalid
    drive_ld(32'h200, F3_W, 5'd9); dmem.gnt = 1;
    #1;
    chk("rr_c0_stall", mem_stall, 1);
    tick(); dmem.gnt = 0;
    #1;
    chk("rr_resp_req", dmem.req, 0);
    rst = 1; clr_ex();
    #1;
    chk("rr_wb_valid", wb_valid, 0);
    chk("rr_wb_alu", wb_alu_res, 0);
    chk("rr_wb_data", wb_mem_data, 0);
    chk("rr_req", dmem.req, 0);
    tick(); tick();
    rst = 0;
    tick(); dmem.rvalid = 1; dmem.rdata = 32'h11111111;
    #1;
    chk("rr_stale_stall", mem_stall, 0);
    tick();
    drive_ld(32'h300, F3_W, 5'd10); dmem.gnt = 0; dmem.rvalid = 1;
    #1;
    chk("rr_idle_req", dmem.req, 1);
    chk("rr_idle_stall", mem_stall, 1);
    tick(); dmem.rvalid = 0; dmem.gnt = 1;
    chk("rr_idle_bubble", wb_valid, 0);
    tick(); dmem.gnt = 0; dmem.rvalid = 1; dmem.rdata = 32'hCAFEF00D;
    #1;
    chk("rr_ld_done", mem_stall, 0);
    tick(); dmem.rvalid = 0;
    chk("rr_ld_data", wb_mem_data, 32'hCAFEF00D);
    chk("rr_ld_valid", wb_valid, 1);

`ifdef MEM_MISALIGN_TRAP_EN
    drive_ld(32'h102, F3_W, 5'd11);
    #1;
    chk("mis_req", dmem.req, 0);
    chk("mis_stall", mem_stall, 0);
    tick();
    chk("mis_flag", wb_misalign, 1);
    chk("mis_regwr", wb_reg_write, 0);
`endif

    clr_ex();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised MEM pipeline stage: successor to the single-cycle word-only MEM stage.
- Adds sized loads/stores (byte/half/word, plus double when XLEN=64) with sign/zero extension.
- Drives an external data-memory request/grant/response bus with variable latency and stalls the pipeline while an access is outstanding.
- Sits between the EX/MEM and MEM/WB registers; it owns the MEM/WB register and the branch-taken decision.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ADDR_W, 32, data-memory address width.
- NBYTES, XLEN/8, byte lanes (derived; not overridable).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  EX/MEM holds a real instruction
- ex_alu_res  in  XLEN  ALU result / effective address
- ex_wdata  in  XLEN  store data (unshifted)
- ex_rd  in  5  destination register
- ex_funct3  in  3  access size/sign (RISC-V load/store encoding)
- ex_branch, ex_zero, ex_mem_read, ex_mem_write, ex_mem2reg, ex_reg_write  in  1 each  control
- flush  in  1  insert bubble into MEM/WB
- dmem_req  out  1  request valid
- dmem_we  out  1  1=store
- dmem_addr  out  ADDR_W  address, aligned to NBYTES
- dmem_wdata  out  XLEN  lane-steered store data
- dmem_be  out  NBYTES  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  load data (full aligned word)
- mem_stall  out  1  hold IF..EX/MEM this cycle
- pc_src  out  1  branch taken
- wb_valid, wb_mem2reg, wb_reg_write  out  1 each  MEM/WB control
- wb_rd  out  5  MEM/WB destination register
- wb_mem_data, wb_alu_res  out  XLEN  MEM/WB data

Behaviour:
- Access condition: acc = ex_valid & (ex_mem_read | ex_mem_write). If both read and write are set, write wins.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if acc, assert dmem_req combinationally. On gnt, a store is done; a load goes to RESP. With no gnt, go to REQ.
  - REQ: hold dmem_req and all dmem_* outputs stable until gnt, then apply the same rules as IDLE.
  - RESP: dmem_req=0. On rvalid, the load is done and the FSM returns to IDLE.
- done = (store & gnt in IDLE/REQ) | (rvalid in RESP).
- mem_stall = acc & ~done (combinational). Upstream holds EX/MEM stable while mem_stall=1.
- Latency:
  - Store granted the same cycle: 0 stall cycles.
  - Load with gnt in cycle N and rvalid in cycle N+k: stalls in cycles N..N+k-1; data captured into MEM/WB at the end of cycle N+k.
- Store steering (off = addr mod NBYTES):
  - SB: be = 1<<off, byte replicated across all lanes.
  - SH: be = 3<<off.
  - SW: be = 0xF<<off.
  - SD (XLEN=64, funct3=011): all lanes.
  - funct3=011 at XLEN=32 is treated as SW.
- Load extraction: shift dmem_rdata right by off*8, then:
  - LB/LH/LW: sign-extend.
  - LBU/LHU/LWU: zero-extend.
  - LD: pass through.
- dmem_addr = address with low log2(NBYTES) bits cleared.
- MEM/WB capture, every edge:
  - flush=1 or mem_stall=1: load a bubble (wb_valid=0, wb_reg_write=0, wb_mem2reg=0; data fields don't-care but deterministic, held).
  - Otherwise capture ex_valid, rd, alu_res, extracted load data, mem2reg, and reg_write & ex_valid.
- pc_src = ex_valid & ex_branch & ex_zero (combinational); unaffected by stall.
- Simultaneous flush and done: the access still completes on the bus; the MEM/WB bubble wins.
- Reset: all wb_* outputs 0, FSM to IDLE, dmem_req=0. A stale rvalid arriving in IDLE after reset is ignored.
- Access is never cancelled once dmem_req has been raised unless rst asserts.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, registered with MEM/WB).
  - An access whose offset is not a multiple of its size raises wb_misalign=1 for that instruction.
  - No dmem_req is issued, no stall occurs, and wb_reg_write is forced to 0.
- Undefined:
  - No port.
  - Low address bits below the access size are ignored (forced alignment), e.g. LW at 0x102 reads lanes 0-3 of 0x100.

Decomposition:
- Package mem_pkg:
  - Funct3 constants F3_B/H/W/D/BU/HU/WU.
  - State typedef {IDLE, REQ, RESP}.
  - Function size_of(funct3).
- Sub-module mem_lsu_align: purely combinational store lane steering/be generation and load extraction/extension, parametrised by XLEN.
- FSM and MEM/WB register stay in the top.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle -> dmem_be=0xF, wdata=0xDEADBEEF, mem_stall never 1, wb_reg_write=0.
- SB addr 0x103, data 0x000000A5 -> be=0x8, wdata=0xA5A5A5A5.
- LB addr 0x101, rdata 0x0000_80_00, gnt cycle 0, rvalid cycle 3 -> mem_stall=1 cycles 0-2, wb_mem_data=0xFFFFFF80. LBU on the same data -> 0x00000080.
- Load with gnt withheld 2 cycles -> FSM REQ, dmem_addr/be stable, no bubble lost. Flush asserted in the rvalid cycle -> wb_valid=0.
- beq with ex_branch=1, ex_zero=1, ex_valid=1 -> pc_src=1 the same cycle. Repeat with ex_valid=0 -> pc_src=0.
- rst asserted in RESP, then rvalid pulse after release -> outputs 0, FSM IDLE, pulse ignored. With MEM_MISALIGN_TRAP_EN: LW 0x102 -> no dmem_req, wb_misalign=1.
